// File: rtl/cpu_pkg.sv
// Shared definitions for the minimal 8-bit CPU: opcodes, instruction field
// positions and common word/register-address types.
package cpu_pkg;
   localparam int DEF_DATA_W = 8;
   localparam int PC_W       = 8;

   localparam logic [3:0] OP_NOP  = 4'h0;
   localparam logic [3:0] OP_ADD  = 4'h1;
   localparam logic [3:0] OP_SUB  = 4'h2;
   localparam logic [3:0] OP_AND  = 4'h3;
   localparam logic [3:0] OP_OR   = 4'h4;
   localparam logic [3:0] OP_XOR  = 4'h5;
   localparam logic [3:0] OP_MOV  = 4'h6;
   localparam logic [3:0] OP_LDI  = 4'h7;
   localparam logic [3:0] OP_SHL  = 4'h8;
   localparam logic [3:0] OP_INC  = 4'h9;
   localparam logic [3:0] OP_OUT  = 4'hA;
   localparam logic [3:0] OP_HALT = 4'hF;

   localparam int OPC_MSB = 7;
   localparam int OPC_LSB = 4;
   localparam int RD_MSB  = 3;
   localparam int RD_LSB  = 2;
   localparam int RS_MSB  = 1;
   localparam int RS_LSB  = 0;

   typedef logic [1:0] reg_addr_t;
   typedef logic [7:0] word_t;

   function automatic logic is_reg_write(input logic [3:0] op);
      return (op >= OP_ADD) && (op <= OP_INC);
   endfunction
endpackage

// File: rtl/cpu_datapath.sv
// Datapath: program counter, ALU, LED output register and the register file.
module cpu_datapath
   import cpu_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [3:0]        op_i,
   input  reg_addr_t         rd_i,
   input  reg_addr_t         rs_i,
   input  logic              reg_write_i,
   output logic [PC_W-1:0]   pc_o,
   output logic [DATA_W-1:0] result_o,
   output logic [3:0]        led_o
);
   logic [PC_W-1:0]   pc;
   logic [3:0]        led_q;
   logic              halted_q;
   logic [DATA_W-1:0] rd_data, rs_data, result;

   cpu_register_file #(.DATA_W(DATA_W)) u_register_file (
      .clk       (clk),
      .reset     (reset),
      .rd_addr_i (rd_i),
      .rs_addr_i (rs_i),
      .we_i      (reg_write_i),
      .wdata_i   (result),
      .rd_data_o (rd_data),
      .rs_data_o (rs_data)
   );

   // Result is forced to zero for every opcode that does not write a register.
   always_comb begin
      result = '0;
      case (op_i)
         OP_ADD:  result = rd_data + rs_data;
         OP_SUB:  result = rd_data - rs_data;
         OP_AND:  result = rd_data & rs_data;
         OP_OR:   result = rd_data | rs_data;
         OP_XOR:  result = rd_data ^ rs_data;
         OP_MOV:  result = rs_data;
         OP_LDI:  result = DATA_W'(rs_i);
         OP_SHL:  result = rd_data << 1;
         OP_INC:  result = rd_data + DATA_W'(1);
         default: result = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         pc       <= '0;
         led_q    <= '0;
         halted_q <= 1'b0;
      end else if (halted_q || op_i == OP_HALT) begin
         halted_q <= 1'b1;
      end else begin
         pc <= pc + 1'b1;
         if (op_i == OP_OUT) led_q <= rd_data[3:0];
      end
   end

   assign pc_o     = pc;
   assign result_o = result;
   assign led_o    = led_q;
endmodule

// File: rtl/cpu_register_file.sv
// 4x8 register file: two combinational read ports, one synchronous write
// port, cleared by the synchronous active-low reset.
module cpu_register_file
   import cpu_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic              clk,
   input  logic              reset,
   input  reg_addr_t         rd_addr_i,
   input  reg_addr_t         rs_addr_i,
   input  logic              we_i,
   input  logic [DATA_W-1:0] wdata_i,
   output logic [DATA_W-1:0] rd_data_o,
   output logic [DATA_W-1:0] rs_data_o
);
   logic [DATA_W-1:0] registers [0:3];

   assign rd_data_o = registers[rd_addr_i];
   assign rs_data_o = registers[rs_addr_i];

   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < 4; i++) registers[i] <= '0;
      end else if (we_i) begin
         registers[rd_addr_i] <= wdata_i;
      end
   end
endmodule

// File: rtl/cpu_top.sv
// Board top of the single-cycle 8-bit CPU: instruction ROM, decode/control
// and the datapath instance. ROM_INIT packs word i at bits [8*i +: 8].
module cpu_top
   import cpu_pkg::*;
#(
   parameter int ROM_DEPTH = 16,
   parameter int DATA_W    = DEF_DATA_W,
   parameter logic [8*ROM_DEPTH-1:0] ROM_INIT =
      {{(ROM_DEPTH-7){8'hF0}}, 8'hF0, 8'hA0, 8'h41, 8'h80, 8'h80, 8'h77, 8'h73}
) (
   input  logic       clk,
   input  logic       reset,
   output logic [3:0] led_out
);
   logic [PC_W-1:0]   pc;
   word_t             instruction;
   logic [3:0]        alu_op;
   logic              reg_write;
   logic [DATA_W-1:0] result_debug;
   reg_addr_t         rd, rs;

   // Addresses past the end of the ROM fetch HALT.
   always_comb begin
      instruction = {OP_HALT, 4'h0};
      if (int'(pc) < ROM_DEPTH) instruction = ROM_INIT[int'(pc)*8 +: 8];
   end

   assign alu_op    = instruction[OPC_MSB:OPC_LSB];
   assign rd        = instruction[RD_MSB:RD_LSB];
   assign rs        = instruction[RS_MSB:RS_LSB];
   assign reg_write = is_reg_write(alu_op);

   cpu_datapath #(.DATA_W(DATA_W)) u_datapath (
      .clk         (clk),
      .reset       (reset),
      .op_i        (alu_op),
      .rd_i        (rd),
      .rs_i        (rs),
      .reg_write_i (reg_write),
      .pc_o        (pc),
      .result_o    (result_debug),
      .led_o       (led_out)
   );
endmodule

// File: tb/tb_cpu_top.sv
// Bench for cpu_top: built-in program plus an alternate ROM image exercising
// wrap-around arithmetic; expectations queued by cycle and checked by a monitor.
module tb_cpu_top;
   logic clk = 1'b0;
   logic reset = 1'b0;
   logic [3:0] led_a, led_b;
   int n = 0;
   int checks = 0;
   int errors = 0;

   localparam logic [8*24-1:0] ALT_ROM = {
      8'hF0, 8'hF0, 8'hF0, 8'hA4, 8'h00, 8'hB5, 8'h61, 8'h39, 8'h56,
      {8{8'h80}}, 8'h9C, 8'h2C, 8'h71, 8'h19, 8'h77, 8'h29, 8'h75};

   cpu_top dut_a (.clk(clk), .reset(reset), .led_out(led_a));
   cpu_top #(.ROM_DEPTH(24), .ROM_INIT(ALT_ROM)) dut_b (.clk(clk), .reset(reset), .led_out(led_b));

   always #5 clk = ~clk;
   always @(posedge clk) n <= n + 1;

   localparam int K_R0 = 0, K_R1 = 1, K_R2 = 2, K_R3 = 3, K_PC = 4, K_LED = 5,
                  K_INS = 6, K_RW = 7, K_AOP = 8, K_RES = 9;

   typedef struct {
      int         c;
      int         d;
      int         k;
      logic [7:0] v;
      string      name;
   } exp_t;
   exp_t sb[$];

   task automatic expect_at(input int c, input int d, input int k, input logic [7:0] v,
                            input string name);
      exp_t e;
      e.c = c; e.d = d; e.k = k; e.v = v; e.name = name;
      sb.push_back(e);
   endtask

   function automatic logic [7:0] actual(input int d, input int k);
      logic [7:0] r;
      r = 8'hxx;
      if (d == 0) begin
         case (k)
            K_R0, K_R1, K_R2, K_R3: r = dut_a.u_datapath.u_register_file.registers[k];
            K_PC:  r = dut_a.u_datapath.pc;
            K_LED: r = {4'h0, led_a};
            K_INS: r = dut_a.instruction;
            K_RW:  r = {7'h0, dut_a.reg_write};
            K_AOP: r = {4'h0, dut_a.alu_op};
            K_RES: r = dut_a.result_debug;
            default: r = 8'hxx;
         endcase
      end else begin
         case (k)
            K_R0, K_R1, K_R2, K_R3: r = dut_b.u_datapath.u_register_file.registers[k];
            K_PC:  r = dut_b.u_datapath.pc;
            K_LED: r = {4'h0, led_b};
            K_INS: r = dut_b.instruction;
            K_RW:  r = {7'h0, dut_b.reg_write};
            K_AOP: r = {4'h0, dut_b.alu_op};
            K_RES: r = dut_b.result_debug;
            default: r = 8'hxx;
         endcase
      end
      return r;
   endfunction

   // Monitor: every falling edge, check whatever is due in the current cycle.
   initial begin
      logic [7:0] got;
      forever begin
         @(negedge clk);
         for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].c == n) begin
               got = actual(sb[i].d, sb[i].k);
               checks++;
               if (got !== sb[i].v) begin
                  errors++;
                  $display("FAIL %s dut%0d cycle %0d: got %h expected %h",
                           sb[i].name, sb[i].d, n, got, sb[i].v);
               end
               sb.delete(i);
            end
         end
      end
   end

   task automatic step(input logic r);
      reset = r;
      @(posedge clk);
      #2;
   endtask

   task automatic expect_reset(input int c, input int d);
      for (int i = 0; i < 4; i++) expect_at(c, d, i, 8'h00, "reset_reg");
      expect_at(c, d, K_PC, 8'h00, "reset_pc");
      expect_at(c, d, K_LED, 8'h00, "reset_led");
   endtask

   initial begin
      // Built-in program
      expect_at(2, 0, K_PC, 8'h00, "pc_in_reset");
      expect_reset(5, 0);
      expect_at(5, 0, K_INS, 8'h73, "first_instr");
      expect_at(5, 0, K_RW,  8'h01, "ldi_rw");
      expect_at(5, 0, K_AOP, 8'h07, "ldi_aop");
      expect_at(5, 0, K_RES, 8'h03, "ldi_res");
      expect_at(6, 0, K_R0, 8'h03, "ldi_r0");
      expect_at(7, 0, K_R1, 8'h03, "ldi_r1");
      expect_at(8, 0, K_R0, 8'h06, "shl1_r0");
      expect_at(9, 0, K_R0, 8'h0C, "shl2_r0");
      expect_at(10, 0, K_R0, 8'h0F, "or_r0");
      expect_at(10, 0, K_INS, 8'hA0, "out_instr");
      expect_at(10, 0, K_RW,  8'h00, "out_rw");
      expect_at(10, 0, K_AOP, 8'h0A, "out_aop");
      expect_at(10, 0, K_LED, 8'h00, "led_before_out");
      expect_at(11, 0, K_LED, 8'h0F, "led_after_out");
      expect_at(11, 0, K_AOP, 8'h0F, "halt_aop");
      expect_at(11, 0, K_RW,  8'h00, "halt_rw");
      expect_at(11, 0, K_RES, 8'h00, "halt_res");
      expect_at(45, 0, K_PC,  8'h06, "halted_pc");
      expect_at(45, 0, K_INS, 8'hF0, "halted_instr");
      expect_at(45, 0, K_RW,  8'h00, "halted_rw");
      expect_at(45, 0, K_LED, 8'h0F, "halted_led");
      expect_at(45, 0, K_R0, 8'h0F, "halted_r0");
      expect_at(45, 0, K_R1, 8'h03, "halted_r1");
      expect_at(45, 0, K_R2, 8'h00, "halted_r2");
      expect_at(45, 0, K_R3, 8'h00, "halted_r3");
      expect_reset(46, 0);
      expect_at(49, 0, K_R0, 8'h06, "rerun_r0");
      expect_at(49, 0, K_PC, 8'h03, "rerun_pc");
      expect_reset(50, 0);
      expect_at(55, 0, K_LED, 8'h00, "restart_led_early");
      expect_at(56, 0, K_LED, 8'h0F, "restart_led");
      expect_at(60, 0, K_PC, 8'h06, "restart_halt_pc");

      // Alternate ROM image
      expect_reset(5, 1);
      expect_at(6, 1, K_R1, 8'h01, "alt_ldi");
      expect_at(6, 1, K_RES, 8'hFF, "alt_sub_res");
      expect_at(6, 1, K_AOP, 8'h02, "alt_sub_aop");
      expect_at(7, 1, K_R2, 8'hFF, "alt_sub_wrap");
      expect_at(8, 1, K_RES, 8'h02, "alt_add_res");
      expect_at(9, 1, K_R2, 8'h02, "alt_add_wrap");
      expect_at(11, 1, K_R3, 8'hFF, "alt_sub_r3");
      expect_at(11, 1, K_RES, 8'h00, "alt_inc_res");
      expect_at(12, 1, K_R3, 8'h00, "alt_inc_wrap");
      expect_at(19, 1, K_R0, 8'h80, "alt_shl_80");
      expect_at(19, 1, K_AOP, 8'h08, "alt_shl_aop");
      expect_at(20, 1, K_R0, 8'h00, "alt_shl_drop");
      expect_at(21, 1, K_R1, 8'h01, "alt_xor");
      expect_at(22, 1, K_R2, 8'h00, "alt_and");
      expect_at(23, 1, K_R0, 8'h01, "alt_mov");
      expect_at(23, 1, K_RW, 8'h00, "alt_undef_rw");
      expect_at(23, 1, K_AOP, 8'h0B, "alt_undef_aop");
      expect_at(23, 1, K_RES, 8'h00, "alt_undef_res");
      expect_at(25, 1, K_R1, 8'h01, "alt_nop_r1");
      expect_at(26, 1, K_LED, 8'h01, "alt_out");
      expect_at(45, 1, K_PC, 8'h15, "alt_halt_pc");
      expect_at(45, 1, K_LED, 8'h01, "alt_halt_led");
      expect_at(45, 1, K_R0, 8'h01, "alt_halt_r0");
      expect_at(45, 1, K_R3, 8'h00, "alt_halt_r3");
      expect_reset(46, 1);

      repeat (5) step(1'b0);
      repeat (40) step(1'b1);
      step(1'b0);
      repeat (3) step(1'b1);
      step(1'b0);
      repeat (10) step(1'b1);
      @(negedge clk);
      #1;
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
